// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// seg7_scan_decoder : recovers the 4-digit value shown on a multiplexed
// active-low 7-segment display, as BCD and as binary.      Rev 1.0
// ============================================================================
module seg7_scan_decoder #(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  anode_in,
   input  logic [6:0]  seg_in,
   input  logic        err_clr,
   output logic [15:0] digit_value,
   output logic [13:0] score_bin,
   output logic        frame_valid,
   output logic        frame_strobe,
   output logic        digit_error
);
   localparam int unsigned CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [TMO_W-1:0] C_TIMEOUT     = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [10:0]      C_IDLE_PINS   = 11'h7FF;

   typedef enum logic [0:0] {SETTLE = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [10:0]      sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [3:0]       mask_q, mask_d;
   logic [3:0][3:0]  digits_q, digits_d;
   logic [15:0]      digit_value_q, digit_value_d;
   logic [13:0]      score_bin_q, score_bin_d;
   logic             frame_valid_q, frame_valid_d;
   logic             frame_strobe_q, frame_strobe_d;
   logic             err_q, err_d;

   logic             changed, sample, slot_ok, dec_ok;
   logic [1:0]       slot;
   logic [3:0]       dec_val;

   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'b0000001: r = {1'b1, 4'd0};
         7'b1001111: r = {1'b1, 4'd1};
         7'b0010010: r = {1'b1, 4'd2};
         7'b0000110: r = {1'b1, 4'd3};
         7'b1001100: r = {1'b1, 4'd4};
         7'b0100100: r = {1'b1, 4'd5};
         7'b0100000: r = {1'b1, 4'd6};
         7'b0001111: r = {1'b1, 4'd7};
         7'b0000000: r = {1'b1, 4'd8};
         7'b0000100: r = {1'b1, 4'd9};
         default:    r = 5'd0;
      endcase
      return r;
   endfunction

   function automatic logic [13:0] bcd_to_bin(input logic [15:0] b);
      return 14'(b[15:12]) * 14'd1000 + 14'(b[11:8]) * 14'd100
           + 14'(b[7:4]) * 14'd10 + 14'(b[3:0]);
   endfunction

   assign changed = (sync2_q != prev_q);
   assign {dec_ok, dec_val} = decode(sync2_q[6:0]);

   always_comb begin
      slot    = 2'd0;
      slot_ok = 1'b1;
      case (sync2_q[10:7])
         4'b0111: slot = 2'd3;
         4'b1011: slot = 2'd2;
         4'b1101: slot = 2'd1;
         4'b1110: slot = 2'd0;
         default: slot_ok = 1'b0;
      endcase
   end

   // Stability tracker: one sample per unchanged period of SETTLE_CYCLES.
   always_comb begin
      sync1_d = {anode_in, seg_in};
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      state_d = state_q;
      count_d = count_q;
      sample  = 1'b0;
      if (changed) begin
         state_d = SETTLE;
         count_d = '0;
      end else if (state_q == SETTLE) begin
         if (count_q == C_SETTLE_LAST) begin
            sample  = 1'b1;
            state_d = HOLD;
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_comb begin
      mask_d         = mask_q;
      digits_d       = digits_q;
      digit_value_d  = digit_value_q;
      score_bin_d    = score_bin_q;
      frame_valid_d  = frame_valid_q;
      frame_strobe_d = 1'b0;
      err_d          = err_q & ~err_clr;
      tmo_d          = (tmo_q < C_TIMEOUT) ? tmo_q + 1'b1 : tmo_q;
      if (tmo_d == C_TIMEOUT) frame_valid_d = 1'b0;
      if (sample && slot_ok) begin
         if (dec_ok) begin
            digits_d[slot] = dec_val;
            mask_d[slot]   = 1'b1;
            // Completing frame overrides the timeout on the same edge.
            if (&mask_d) begin
               digit_value_d  = digits_d;
               score_bin_d    = bcd_to_bin(digits_d);
               frame_strobe_d = 1'b1;
               frame_valid_d  = 1'b1;
               mask_d         = '0;
               tmo_d          = '0;
            end
         end else begin
            err_d  = 1'b1;
            mask_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q        <= C_IDLE_PINS;
         sync2_q        <= C_IDLE_PINS;
         prev_q         <= C_IDLE_PINS;
         state_q        <= SETTLE;
         count_q        <= '0;
         tmo_q          <= '0;
         mask_q         <= '0;
         digits_q       <= '0;
         digit_value_q  <= '0;
         score_bin_q    <= '0;
         frame_valid_q  <= 1'b0;
         frame_strobe_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         prev_q         <= prev_d;
         state_q        <= state_d;
         count_q        <= count_d;
         tmo_q          <= tmo_d;
         mask_q         <= mask_d;
         digits_q       <= digits_d;
         digit_value_q  <= digit_value_d;
         score_bin_q    <= score_bin_d;
         frame_valid_q  <= frame_valid_d;
         frame_strobe_q <= frame_strobe_d;
         err_q          <= err_d;
      end
   end

   assign digit_value  = digit_value_q;
   assign score_bin    = score_bin_q;
   assign frame_valid  = frame_valid_q;
   assign frame_strobe = frame_strobe_q;
   assign digit_error  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// tb_seg7_scan_decoder : directed and randomized checks against a digit-level
// model of what a viewer of the display would read.
module tb_seg7_scan_decoder;
   localparam int SETTLE = 16;
   localparam int TMO    = 1000;
   localparam int LONG   = 40;
   localparam int SHORT  = 10;
   localparam int GAP    = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  anode_in = 4'hF;
   logic [6:0]  seg_in = 7'h7F;
   logic        err_clr = 1'b0;
   logic [15:0] digit_value;
   logic [13:0] score_bin;
   logic        frame_valid, frame_strobe, digit_error;

   int n_checks = 0, n_fail = 0;
   int cyc = 0, strobe_cnt = 0, strobe_cyc = 0;

   // Model: what has been shown on each digit and what a full frame reads as.
   int          m_dig[4];
   logic [3:0]  m_mask;
   int          m_err, m_strobes, m_value;
   logic [15:0] m_bcd;

   seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .anode_in(anode_in), .seg_in(seg_in),
      .err_clr(err_clr), .digit_value(digit_value), .score_bin(score_bin),
      .frame_valid(frame_valid), .frame_strobe(frame_strobe), .digit_error(digit_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (frame_strobe === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      strobe_cyc <= cyc;
   end

   function automatic logic [6:0] seg_pat(input int d);
      case (d)
         0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
         3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
         6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
         default: return 7'b0000100;
      endcase
   endfunction

   function automatic logic [3:0] an_of(input int slot);
      return ~(4'b0001 << slot);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      m_mask = 4'h0; m_err = 0; m_value = 0; m_bcd = 16'h0;
   endtask

   task automatic model_sample(input logic [3:0] an, input logic [6:0] sg);
      int slot, d;
      slot = -1;
      d = -1;
      for (int i = 0; i < 4; i++) if (an == an_of(i)) slot = i;
      if (slot < 0) return;
      for (int k = 0; k < 10; k++) if (seg_pat(k) == sg) d = k;
      if (d < 0) begin
         m_err = 1;
         m_mask = 4'h0;
         return;
      end
      m_dig[slot] = d;
      m_mask[slot] = 1'b1;
      if (m_mask == 4'hF) begin
         m_strobes++;
         m_value = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
         m_bcd = 16'(m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0]);
         m_mask = 4'h0;
      end
   endtask

   // Show one pattern for a number of cycles, then blank briefly.
   task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int cycles);
      @(negedge clk);
      anode_in = an;
      seg_in = sg;
      repeat (cycles - 1) @(negedge clk);
      if (cycles >= 30) model_sample(an, sg);
      anode_in = 4'hF;
      seg_in = 7'h7F;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic pulse_err_clr();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      m_err = 0;
   endtask

   task automatic test_reset();
      model_reset();
      m_strobes = 0;
      repeat (3) @(negedge clk);
      n_checks++; if ({digit_value, score_bin, frame_valid, frame_strobe, digit_error} !== 33'h0) begin
         n_fail++; $display("FAIL reset_outputs: got %h/%0d/%b/%b/%b want all zero",
                            digit_value, score_bin, frame_valid, frame_strobe, digit_error);
      end
      reset = 1'b0;
      repeat (30) @(negedge clk);
      n_checks++; if (strobe_cnt !== 0) begin
         n_fail++; $display("FAIL reset_idle_strobe: got %0d strobes want 0", strobe_cnt);
      end
   endtask

   task automatic test_basic_frame();
      drive(an_of(3), seg_pat(0), LONG);
      drive(an_of(2), seg_pat(1), LONG);
      drive(an_of(1), seg_pat(2), LONG);
      drive(an_of(0), seg_pat(5), LONG);
      n_checks++; if (strobe_cnt !== 1) begin
         n_fail++; $display("FAIL basic_strobe_count: got %0d want 1", strobe_cnt);
      end
      n_checks++; if (digit_value !== 16'h0125) begin
         n_fail++; $display("FAIL basic_bcd: got %h want 0125", digit_value);
      end
      n_checks++; if (score_bin !== 14'd125) begin
         n_fail++; $display("FAIL basic_bin: got %0d want 125", score_bin);
      end
      n_checks++; if (frame_valid !== 1'b1 || digit_error !== 1'b0) begin
         n_fail++; $display("FAIL basic_flags: valid %b err %b want 1 0", frame_valid, digit_error);
      end
   endtask

   task automatic test_short_hold();
      drive(an_of(3), seg_pat(3), LONG);
      drive(an_of(2), seg_pat(4), LONG);
      drive(an_of(1), seg_pat(5), SHORT);
      drive(an_of(0), seg_pat(6), LONG);
      n_checks++; if (strobe_cnt !== m_strobes || strobe_cnt !== 1) begin
         n_fail++; $display("FAIL short_no_strobe: got %0d strobes want 1", strobe_cnt);
      end
      drive(an_of(1), seg_pat(5), LONG);
      n_checks++; if (strobe_cnt !== 2) begin
         n_fail++; $display("FAIL short_retry_strobe: got %0d strobes want 2", strobe_cnt);
      end
      n_checks++; if (digit_value !== 16'h3456 || score_bin !== 14'd3456) begin
         n_fail++; $display("FAIL short_value: got %h/%0d want 3456", digit_value, score_bin);
      end
   endtask

   task automatic test_invalid();
      drive(an_of(3), seg_pat(7), LONG);
      drive(4'b1101, 7'b1111111, LONG);
      n_checks++; if (digit_error !== 1'b1) begin
         n_fail++; $display("FAIL invalid_sets_err: got %b want 1", digit_error);
      end
      drive(an_of(2), seg_pat(1), LONG);
      drive(an_of(1), seg_pat(0), LONG);
      drive(an_of(0), seg_pat(0), LONG);
      n_checks++; if (strobe_cnt !== 2) begin
         n_fail++; $display("FAIL invalid_mask_cleared: got %0d strobes want 2", strobe_cnt);
      end
      drive(an_of(3), seg_pat(1), LONG);
      n_checks++; if (digit_value !== 16'h1100 || score_bin !== 14'd1100 || strobe_cnt !== 3) begin
         n_fail++; $display("FAIL invalid_next_frame: got %h/%0d/%0d want 1100/1100/3",
                            digit_value, score_bin, strobe_cnt);
      end
      n_checks++; if (digit_error !== 1'b1) begin
         n_fail++; $display("FAIL invalid_err_sticky: got %b want 1", digit_error);
      end
      pulse_err_clr();
      n_checks++; if (digit_error !== 1'b0) begin
         n_fail++; $display("FAIL invalid_err_clr: got %b want 0", digit_error);
      end
   endtask

   task automatic test_no_sample();
      drive(4'b1111, 7'b0000000, 100);
      drive(4'b0011, 7'b0000000, 100);
      n_checks++; if (strobe_cnt !== 3 || digit_error !== 1'b0) begin
         n_fail++; $display("FAIL nosample_idle: got %0d strobes err %b want 3 0", strobe_cnt, digit_error);
      end
      // Thousands/hundreds were only ever shown together, so no frame yet.
      drive(an_of(1), seg_pat(2), LONG);
      drive(an_of(0), seg_pat(2), LONG);
      drive(an_of(2), seg_pat(2), LONG);
      n_checks++; if (strobe_cnt !== 3) begin
         n_fail++; $display("FAIL nosample_multi_low: got %0d strobes want 3", strobe_cnt);
      end
      drive(an_of(3), seg_pat(2), LONG);
      n_checks++; if (strobe_cnt !== m_strobes || digit_value !== 16'h2222) begin
         n_fail++; $display("FAIL nosample_frame: got %0d/%h want %0d/2222", strobe_cnt, digit_value, m_strobes);
      end
   endtask

   task automatic test_timeout();
      int waited;
      drive(an_of(3), seg_pat(4), LONG);
      drive(an_of(2), seg_pat(3), LONG);
      drive(an_of(1), seg_pat(2), LONG);
      drive(an_of(0), seg_pat(1), LONG);
      n_checks++; if (frame_valid !== 1'b1) begin
         n_fail++; $display("FAIL timeout_valid_after_frame: got %b want 1", frame_valid);
      end
      waited = 0;
      while (frame_valid === 1'b1 && waited < 1200) begin
         @(negedge clk);
         waited++;
      end
      n_checks++; if (frame_valid !== 1'b0 || cyc - strobe_cyc !== TMO) begin
         n_fail++; $display("FAIL timeout_delay: valid %b after %0d cycles want 0 after %0d",
                            frame_valid, cyc - strobe_cyc, TMO);
      end
      n_checks++; if (digit_value !== 16'h4321 || score_bin !== 14'd4321) begin
         n_fail++; $display("FAIL timeout_retain: got %h/%0d want 4321", digit_value, score_bin);
      end
   endtask

   task automatic test_reset_midframe();
      drive(an_of(3), seg_pat(8), LONG);
      drive(an_of(2), seg_pat(8), LONG);
      @(posedge clk);
      #2;
      reset = 1'b1;
      anode_in = 4'hF;
      seg_in = 7'h7F;
      #1;
      n_checks++; if ({digit_value, score_bin, frame_valid, frame_strobe, digit_error} !== 33'h0) begin
         n_fail++; $display("FAIL midreset_outputs: got %h/%0d/%b/%b/%b want all zero",
                            digit_value, score_bin, frame_valid, frame_strobe, digit_error);
      end
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      drive(an_of(1), seg_pat(9), LONG);
      drive(an_of(0), seg_pat(9), LONG);
      n_checks++; if (strobe_cnt !== m_strobes || digit_value !== 16'h0) begin
         n_fail++; $display("FAIL midreset_partial: got %0d/%h want %0d/0000", strobe_cnt, digit_value, m_strobes);
      end
      drive(an_of(3), seg_pat(9), LONG);
      drive(an_of(2), seg_pat(9), LONG);
      n_checks++; if (score_bin !== 14'd9999 || digit_value !== 16'h9999 || strobe_cnt !== m_strobes) begin
         n_fail++; $display("FAIL midreset_9999: got %0d/%h/%0d want 9999/9999/%0d",
                            score_bin, digit_value, strobe_cnt, m_strobes);
      end
   endtask

   task automatic test_random();
      int slot, dur, tries;
      logic [6:0] pat;
      logic hit;
      pulse_err_clr();
      for (int step = 0; step < 30; step++) begin
         slot = $urandom_range(0, 3);
         if ($urandom_range(0, 9) == 0) begin
            tries = 0;
            do begin
               pat = 7'($urandom);
               hit = 1'b0;
               for (int k = 0; k < 10; k++) if (seg_pat(k) == pat) hit = 1'b1;
               tries++;
            end while (hit && tries < 100);
            if (hit) pat = 7'b1111111;
         end else begin
            pat = seg_pat($urandom_range(0, 9));
         end
         dur = ($urandom_range(0, 4) == 0) ? SHORT : LONG;
         drive(an_of(slot), pat, dur);
         n_checks++; if (strobe_cnt !== m_strobes) begin
            n_fail++; $display("FAIL rand_strobes[%0d]: got %0d want %0d", step, strobe_cnt, m_strobes);
         end
         n_checks++; if (digit_value !== m_bcd || score_bin !== 14'(m_value)) begin
            n_fail++; $display("FAIL rand_value[%0d]: got %h/%0d want %h/%0d",
                               step, digit_value, score_bin, m_bcd, m_value);
         end
         n_checks++; if (digit_error !== 1'(m_err)) begin
            n_fail++; $display("FAIL rand_err[%0d]: got %b want %0d", step, digit_error, m_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_short_hold();
      test_invalid();
      test_no_sample();
      test_timeout();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Receive-side counterpart of the multiplexed 7-segment score display. It samples the active-low anode/segment lines and decodes each segment pattern back into a BCD digit. It assembles the four digits into a frame and reports the displayed value in both BCD and binary. It serves as an on-board loopback checker for the score path and as a bench monitor for display drivers.

Parameters:
SETTLE_CYCLES, 16, consecutive unchanged clk cycles required on {anode_in, seg_in} before a digit is sampled (min 2).
TIMEOUT_CYCLES, 100000, clk cycles after the last frame_strobe before frame_valid drops.

Ports:
clk  in  1  board clock; all logic is on its rising edge.
reset  in  1  asynchronous, active-high reset.
anode_in  in  4  active-low digit enables: 0111=thousands, 1011=hundreds, 1101=tens, 1110=ones.
seg_in  in  7  active-low segments, bit6=a ... bit0=g.
err_clr  in  1  synchronous clear of digit_error.
digit_value  out  16  last complete frame in BCD; [15:12]=thousands.
score_bin  out  14  binary equivalent of digit_value (0..9999).
frame_valid  out  1  a frame has completed within the last TIMEOUT_CYCLES.
frame_strobe  out  1  one-cycle pulse per completed frame.
digit_error  out  1  sticky; an invalid segment pattern was sampled.

Behaviour:
- Reset (async): sync flops anode=4'hF, seg=7'h7F; counters=0; capture mask=0; captured digits=0; all outputs=0; FSM=SETTLE.
- Input stage: 2-flop synchroniser on anode_in and seg_in; 2-cycle latency.
- Stability FSM:
  - SETTLE: count increments while the synced {anode,seg} equals the previous cycle's value.
  - Any change in any state: count goes to 0 and the FSM enters SETTLE.
  - When count reaches SETTLE_CYCLES-1 with no change: take one sample event and go to HOLD.
  - HOLD: no further samples until the inputs change. Exactly one sample per stable period.
- Sample event: acted on only when the anode has exactly one bit low. For 1111 or multiple lows, take no action and set no error.
- Decode table (seg → digit):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4.
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
- Valid pattern: write the nibble to the anode's digit slot and set its mask bit. Re-sampling an already-captured slot overwrites it.
- Invalid pattern: set digit_error and clear the mask (frame aborted). Stored digit slots are don't-care until recaptured.
- Frame completion: on the edge where the sample makes mask==1111:
  - digit_value <= the four slots, with the new nibble included.
  - score_bin <= d3*1000 + d2*100 + d1*10 + d0, computed without truncation into 14 bits.
  - frame_strobe=1 for exactly one cycle; frame_valid=1.
  - mask <= 0; timeout counter <= 0.
- Capture order is irrelevant; only set membership counts.
- Timeout: counter increments each cycle after a frame and saturates at TIMEOUT_CYCLES. On reaching it, frame_valid <= 0. digit_value and score_bin hold their last values.
- A frame completion on the same cycle as the timeout wins: frame_valid stays 1.
- digit_error is cleared by err_clr. If err_clr coincides with a new invalid sample, set wins.
- Latency: pin change → frame_strobe for the 4th digit = 2 + SETTLE_CYCLES cycles (±1 for the sync edge).
- Reset mid-frame: partial mask is discarded; the next frame requires all four digits.

Test Plan:
1. SETTLE=16. Drive 0111/0000001, 1011/1001111, 1101/0010010, 1110/0100100, each for 40 cycles → one frame_strobe; digit_value=16'h0125; score_bin=125; frame_valid=1; digit_error=0.
2. Hold a tens digit for only 10 cycles, then advance → no capture of that digit and no strobe. Repeat it for 40 cycles → strobe occurs.
3. Drive 1101/1111111 for 40 cycles → digit_error=1 and mask cleared. Then a full frame 1,1,0,0 → digit_value=16'h1100, score_bin=1100, digit_error still 1. Pulse err_clr → 0.
4. Drive anode 1111, then 0011, each for 100 cycles with seg=0000000 → no sample, no error, no strobe.
5. TIMEOUT=1000. After one valid frame, hold anode=1111 → frame_valid falls exactly 1000 cycles after the strobe; digit_value is retained.
6. Capture 2 digits, assert reset mid-cycle → outputs 0 immediately. Capture the 2 remaining digits only → no strobe until all 4 are captured. Frame 9,9,9,9 → score_bin=9999.
